// File: rtl/data_ram_arbiter.sv
// Arbitrates the single-port data RAM between the CPU (port C) and the host/debug port (port H).
// Optional DATA_RAM_ARB_STATS_EN adds stall/grant statistics counters with a synchronous clear.
module data_ram_arbiter #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 15,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_gnt,
   output logic                  cpu_rvalid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic                  host_gnt,
   output logic                  host_rvalid,
   output logic [DATA_WIDTH-1:0] host_rdata,
   input  logic                  host_lock,
   output logic                  host_locked,
`ifdef DATA_RAM_ARB_STATS_EN
   input  logic                  stats_clr,
   output logic [15:0]           cpu_stall_cnt,
   output logic [15:0]           host_grant_cnt,
`endif
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {CPU_PRI, HOST_FORCE, LOCKED} state_t;

   state_t                r_state, w_state_nxt;
   logic [CW-1:0]         r_starve_cnt, w_cnt_nxt;
   logic                  w_cpu_sel, w_host_sel;
   logic                  r_cpu_rd, r_host_rd, r_host_locked;
   logic [ADDR_WIDTH-1:0] r_last_addr;

   always_comb begin
      w_cpu_sel  = 1'b0;
      w_host_sel = 1'b0;
      case (r_state)
         CPU_PRI: begin
            w_cpu_sel  = 1'b1;
            w_host_sel = !cpu_req;
         end
         HOST_FORCE: begin
            w_host_sel = 1'b1;
            w_cpu_sel  = !host_req;
         end
         LOCKED:  w_host_sel = 1'b1;
         default: w_cpu_sel  = 1'b1;
      endcase
   end

   // Grants are forced low while reset is asserted, independent of the state register.
   assign cpu_gnt  = rst_n && cpu_req  && w_cpu_sel;
   assign host_gnt = rst_n && host_req && w_host_sel;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_starve_cnt;
      case (r_state)
         CPU_PRI: begin
            if (host_req && !host_gnt)
               w_cnt_nxt = (r_starve_cnt == LIMIT) ? r_starve_cnt : r_starve_cnt + 1'b1;
            else
               w_cnt_nxt = '0;
            if (w_cnt_nxt == LIMIT)
               w_state_nxt = HOST_FORCE;
         end
         HOST_FORCE: begin
            if (host_gnt || !host_req) begin
               w_state_nxt = CPU_PRI;
               w_cnt_nxt   = '0;
            end
         end
         LOCKED: begin
            if (!host_lock) begin
               w_state_nxt = CPU_PRI;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = CPU_PRI;
            w_cnt_nxt   = '0;
         end
      endcase
      // Lock request overrides any starvation transition.
      if (r_state != LOCKED && host_lock) begin
         w_state_nxt = LOCKED;
         w_cnt_nxt   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= CPU_PRI;
         r_starve_cnt  <= '0;
         r_cpu_rd      <= 1'b0;
         r_host_rd     <= 1'b0;
         r_host_locked <= 1'b0;
         r_last_addr   <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_starve_cnt  <= w_cnt_nxt;
         r_cpu_rd      <= cpu_gnt && !cpu_we;
         r_host_rd     <= host_gnt && !host_we;
         r_host_locked <= (w_state_nxt == LOCKED);
         if (cpu_gnt)
            r_last_addr <= cpu_addr;
         else if (host_gnt)
            r_last_addr <= host_addr;
      end
   end

   assign ram_addr  = cpu_gnt ? cpu_addr  : (host_gnt ? host_addr  : r_last_addr);
   assign ram_wdata = cpu_gnt ? cpu_wdata : (host_gnt ? host_wdata : '0);
   assign ram_we    = (cpu_gnt && cpu_we) || (host_gnt && host_we);

   assign cpu_rvalid  = r_cpu_rd;
   assign host_rvalid = r_host_rd;
   assign cpu_rdata   = r_cpu_rd  ? ram_rdata : '0;
   assign host_rdata  = r_host_rd ? ram_rdata : '0;
   assign host_locked = r_host_locked;

`ifdef DATA_RAM_ARB_STATS_EN
   logic [15:0] r_cpu_stall_cnt, r_host_grant_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cpu_stall_cnt  <= '0;
         r_host_grant_cnt <= '0;
      end else if (stats_clr) begin
         r_cpu_stall_cnt  <= '0;
         r_host_grant_cnt <= '0;
      end else begin
         if (cpu_req && !cpu_gnt && r_cpu_stall_cnt != 16'hFFFF)
            r_cpu_stall_cnt <= r_cpu_stall_cnt + 16'd1;
         if (host_gnt && r_host_grant_cnt != 16'hFFFF)
            r_host_grant_cnt <= r_host_grant_cnt + 16'd1;
      end
   end

   assign cpu_stall_cnt  = r_cpu_stall_cnt;
   assign host_grant_cnt = r_host_grant_cnt;
`endif

endmodule
